// File: rtl/xnor_truth_table_sequencer_if.sv
// xnor_truth_table_sequencer_if: stimulus/result bundle between the sequencer and its user
interface xnor_truth_table_sequencer_if;
   logic       start;
   logic       f;
   logic       A;
   logic       B;
   logic       C;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] err_count;
   logic [7:0] fail_vec;
   logic [7:0] captured;
   modport master (output start, f, input A, B, C, busy, done, pass, err_count, fail_vec, captured);
   modport slave (input start, f, output A, B, C, busy, done, pass, err_count, fail_vec, captured);
endinterface

// File: rtl/xnor_truth_table_sequencer.sv
// xnor_truth_table_sequencer: sweeps {A,B,C} 000..111 and checks f against EXPECT; XTTS_STOP_ON_FAIL_EN halts on first mismatch
module xnor_truth_table_sequencer #(
   parameter int         DWELL  = 4,
   parameter logic [7:0] EXPECT = 8'h69
) (
   input logic                         clk,
   input logic                         rst,
   xnor_truth_table_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
`ifdef XTTS_STOP_ON_FAIL_EN
      , HALT
`endif
   } state_t;
   localparam logic [7:0] LAST = 8'(DWELL - 1);
   state_t     state, state_n;
   logic [2:0] vec, vec_n;
   logic [7:0] cnt, cnt_n;
   logic [3:0] err, err_n;
   logic [7:0] fail, fail_n;
   logic [7:0] cap, cap_n;
   logic       miss, done;
   assign miss = bus.f != EXPECT[vec];
   assign done = state != IDLE && state != RUN;
   assign {bus.A, bus.B, bus.C} = vec;
   assign bus.busy = state == RUN;
   assign bus.done = done;
   assign bus.pass = done && err == 4'd0;
   assign bus.err_count = err;
   assign bus.fail_vec = fail;
   assign bus.captured = cap;
   // next state and datapath: start clears results, each dwell's last cycle samples f
   always_comb begin
      state_n = state;
      vec_n = vec;
      cnt_n = cnt;
      err_n = err;
      fail_n = fail;
      cap_n = cap;
      if (state != RUN && bus.start) begin
         state_n = RUN;
         vec_n = 3'd0;
         cnt_n = 8'd0;
         err_n = 4'd0;
         fail_n = 8'd0;
         cap_n = 8'd0;
      end else if (state == RUN) begin
         if (cnt != LAST) cnt_n = cnt + 8'd1;
         else begin
            cap_n[vec] = bus.f;
            if (miss) begin
               fail_n[vec] = 1'b1;
               err_n = err + 4'd1;
            end
`ifdef XTTS_STOP_ON_FAIL_EN
            if (miss) state_n = HALT;
            else
`endif
            if (vec == 3'd7) state_n = DONE;
            else begin
               vec_n = vec + 3'd1;
               cnt_n = 8'd0;
            end
         end
      end
   end
   // state and result registers; reset discards any partial sweep
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         vec <= 3'd0;
         cnt <= 8'd0;
         err <= 4'd0;
         fail <= 8'd0;
         cap <= 8'd0;
      end else begin
         state <= state_n;
         vec <= vec_n;
         cnt <= cnt_n;
         err <= err_n;
         fail <= fail_n;
         cap <= cap_n;
      end
   end
endmodule

// File: tb/tb_xnor_truth_table_sequencer.sv
// tb_xnor_truth_table_sequencer: scoreboard bench driving f from a selectable model (correct, stuck-0, stuck-1)
module tb_xnor_truth_table_sequencer;
   localparam int         DW  = 4;
   localparam logic [7:0] EXP = 8'h69;
   typedef struct {
      int         cyc;
      logic [3:0] err;
      logic [7:0] fail;
      logic [7:0] cap;
      logic       pass;
      logic [2:0] last;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   mode = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t q[$];
   xnor_truth_table_sequencer_if bus ();
   xnor_truth_table_sequencer #(.DWELL(DW), .EXPECT(EXP)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   // f model: 0 = correct XNOR, 1 = stuck at 0, 2 = stuck at 1
   always_comb bus.f = mode == 0 ? ~(bus.A ^ bus.B ^ bus.C) : mode == 2;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask
   task automatic check_idle(input string tag);
      check({tag, "_abc"}, {bus.A, bus.B, bus.C}, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_pass"}, bus.pass, 0);
      check({tag, "_err"}, bus.err_count, 0);
      check({tag, "_fail"}, bus.fail_vec, 0);
      check({tag, "_cap"}, bus.captured, 0);
   endtask
   task automatic sweep(input int m);
      exp_t       e;
      int         nv, k;
      logic [2:0] v;
      logic       fv;
      mode = m;
      e.err = 0;
      e.fail = 0;
      e.cap = 0;
      nv = 8;
      for (int i = 0; i < 8; i++) begin
         if (i < nv) begin
            v = i[2:0];
            fv = m == 0 ? ~(^v) : m == 2;
            e.cap[i] = fv;
            if (fv != EXP[i]) begin
               e.fail[i] = 1'b1;
               e.err = e.err + 4'd1;
`ifdef XTTS_STOP_ON_FAIL_EN
               nv = i + 1;
`endif
            end
         end
      end
      e.cyc = DW * nv;
      e.pass = e.err == 0;
      e.last = 3'(nv - 1);
      q.push_back(e);
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      k = 0;
      check("clr_err", bus.err_count, 0);
      check("clr_fail", bus.fail_vec, 0);
      check("clr_cap", bus.captured, 0);
      check("run_busy", bus.busy, 1);
      check("run_done", bus.done, 0);
      while (!bus.done && k < 200) begin
         if (k % DW == 0 && k / DW < nv) check("step_abc", {bus.A, bus.B, bus.C}, k / DW);
         @(negedge clk);
         k++;
      end
      e = q.pop_front();
      check("cycles", k, e.cyc);
      check("err", bus.err_count, e.err);
      check("fail", bus.fail_vec, e.fail);
      check("cap", bus.captured, e.cap);
      check("pass", bus.pass, e.pass);
      check("last_abc", {bus.A, bus.B, bus.C}, e.last);
      check("end_busy", bus.busy, 0);
      repeat (3) @(negedge clk);
      check("hold_abc", {bus.A, bus.B, bus.C}, e.last);
      check("hold_done", bus.done, 1);
   endtask
   initial begin
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle("idle");
      sweep(0);
      sweep(2);
      sweep(0);
      sweep(1);
      mode = 0;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      repeat (12) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      check("mid_abc3", {bus.A, bus.B, bus.C}, 3);
      repeat (3) @(negedge clk);
      check("mid_abc4", {bus.A, bus.B, bus.C}, 4);
      repeat (4) @(negedge clk);
      check("mid_abc5", {bus.A, bus.B, bus.C}, 5);
      check("mid_cap", bus.captured, 8'h09);
      #2 rst = 1'b1;
      #1 check_idle("async_rst");
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check_idle("start_in_rst");
      sweep(0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/xnor_truth_table_sequencer.md
Name: xnor_truth_table_sequencer

Overview:
- Synthesizable upstream stimulus stage for the 3-input SOP XNOR block (A, B, C -> f).
- On start, drives all 8 input combinations 000..111 in ascending order, holding each for DWELL cycles.
- Samples f at the end of each dwell and compares it against a parameterized expected truth table.
- Reports a pass/fail summary, a per-vector fail bitmap and the captured truth table, allowing on-board self-check without a simulator.

Parameters:
- DWELL, 4, cycles each vector is held; legal range 2..255; f is sampled on the last cycle of the dwell.
- EXPECT, 8'h69, expected f per vector; bit i corresponds to {A,B,C}=i; 8'h69 is ~(A^B^C).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a sweep when in IDLE or DONE.
- f  input  1  output of the block under test.
- A  output  1  stimulus MSB.
- B  output  1  stimulus middle bit.
- C  output  1  stimulus LSB.
- busy  output  1  high while a sweep is running.
- done  output  1  high while in DONE; held until next start.
- pass  output  1  done && err_count==0.
- err_count  output  4  number of mismatching vectors, 0..8.
- fail_vec  output  8  bit i set if vector i mismatched.
- captured  output  8  bit i = sampled f for vector i.

Behaviour:
- Reset (async, rst=1): state=IDLE; {A,B,C}=000; busy, done and pass=0; err_count=0; fail_vec=0; captured=0; vec=0; dwell_cnt=0.
- Registers: vec[2:0] drives {A,B,C} directly (registered outputs); dwell_cnt[7:0].
- States: IDLE, RUN, DONE, plus HALT when the optional feature is enabled.
- IDLE or DONE + start=1:
  - Next state is RUN; vec=0; dwell_cnt=0.
  - err_count, fail_vec and captured are cleared in the same edge.
  - done drops to 0 and busy rises to 1.
- RUN, dwell_cnt < DWELL-1: dwell_cnt++; outputs held.
- RUN, dwell_cnt == DWELL-1 (sample edge):
  - captured[vec] <= f.
  - If f != EXPECT[vec]: fail_vec[vec] <= 1 and err_count <= err_count+1.
  - If vec==7: next state is DONE; busy=0; done=1; vec stays 7.
  - Otherwise: vec++ and dwell_cnt=0.
- Timing: sweep length is exactly 8*DWELL cycles from the first RUN cycle; done rises on the edge that samples vector 7.
- start while in RUN is ignored; start in the same cycle as rst is ignored.
- rst asserted mid-sweep returns the block to the reset values immediately; there is no partial result retention.
- err_count saturation is not needed; the maximum value is 8 and it is 4 bits wide.
- In DONE, outputs hold their final values; {A,B,C} stays 111 until the next start or reset.

Optional Feature:
- Macro: XTTS_STOP_ON_FAIL_EN.
- Defined: on the first mismatching sample edge, the block records the mismatch as normal (captured, fail_vec, err_count=1) and moves to HALT instead of advancing.
  - HALT: busy=0, done=1, pass=0; {A,B,C} is held at the failing vector for probing.
  - start from HALT behaves as start from DONE.
- Undefined: no HALT state; every sweep always covers all 8 vectors.

Test Plan:
- Correct model f=~(A^B^C), DWELL=4, start pulse -> {A,B,C} steps 000..111 every 4 cycles; done at cycle 32 after start; pass=1, err_count=0, fail_vec=8'h00, captured=8'h69.
- f stuck at 0 -> err_count=4, fail_vec=8'h69, captured=8'h00, pass=0.
- f stuck at 1 -> err_count=4, fail_vec=8'h96, captured=8'hFF, pass=0.
- Correct model; start pulsed again at vector 3 mid-run, then rst at vector 5 -> second start ignored; after rst, all outputs return to reset values, with A=B=C=0 on the same cycle rst asserts.
- Complete a pass, then issue start from DONE with f stuck at 0 -> results cleared on the start edge; second sweep reports err_count=4 and the fresh fail_vec.
- With XTTS_STOP_ON_FAIL_EN and f stuck at 0 -> halts at vector 0 after 4 cycles; err_count=1, fail_vec=8'h01, {A,B,C}=000 held, done=1, pass=0.
